// File: rtl/md_unit_if.sv
`default_nettype none
// ============================================================================
//  Module      : md_unit_if
//  Description : Request/result bundle between the EX stage and the
//                multiply/divide unit (operands in, HI/LO and status out).
//  Revision    : 1.0  initial release
// ============================================================================
interface md_unit_if #(
  parameter int WIDTH = 32
) ();
  logic             start;
  logic [2:0]       op;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             busy;
  logic             stall;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;

  // Pipeline side: issues instructions, observes status and HI/LO.
  modport master (
    output start, op, a, b,
    input  busy, stall, hi, lo
  );

  // Unit side: consumes instructions, produces status and HI/LO.
  modport slave (
    input  start, op, a, b,
    output busy, stall, hi, lo
  );
endinterface
`default_nettype wire

// File: rtl/md_unit.sv
`default_nettype none
// ============================================================================
//  Module      : md_unit
//  Description : Multi-cycle MULT/MULTU/DIV/DIVU unit with HI/LO registers
//                and MTHI/MTLO writes. Results land after a fixed busy
//                window; a combinational stall covers the whole operation.
//  Revision    : 1.0  initial release
// ============================================================================
module md_unit #(
  parameter int WIDTH       = 32,
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  wire logic  clk,
  input  wire logic  reset,
  md_unit_if.slave   bus
);

  localparam int MAXC = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CW   = $clog2(MAXC + 1);

  // DONE is folded into the final count of MUL/DIV, so it is never entered;
  // it only exists to name the completion point in the encoding.
  typedef enum logic [1:0] {IDLE, MUL, DIV, DONE} state_t;

  state_t           state, state_nxt;
  logic [CW-1:0]    cnt, cnt_nxt;
  logic [WIDTH-1:0] opa, opa_nxt, opb, opb_nxt;
  logic             sgn, sgn_nxt;
  logic [WIDTH-1:0] hi_reg, hi_nxt, lo_reg, lo_nxt;

  logic [2*WIDTH-1:0] ext_a, ext_b, prod;
  logic [WIDTH-1:0]   a_mag, b_mag, q_mag, r_mag, quo, rem;
  logic               neg_q, neg_r;

  // Arithmetic on the captured operands; sign-extending to 2*WIDTH makes
  // the truncated product correct for both signed and unsigned forms.
  always_comb begin
    ext_a = sgn ? {{WIDTH{opa[WIDTH-1]}}, opa} : {{WIDTH{1'b0}}, opa};
    ext_b = sgn ? {{WIDTH{opb[WIDTH-1]}}, opb} : {{WIDTH{1'b0}}, opb};
    prod  = ext_a * ext_b;
    // Signed divide via magnitudes. Most-negative / -1 falls out naturally:
    // the magnitude quotient is 2^(WIDTH-1), which reads back as a, rem 0.
    neg_q = sgn && (opa[WIDTH-1] ^ opb[WIDTH-1]);
    neg_r = sgn && opa[WIDTH-1];
    a_mag = (sgn && opa[WIDTH-1]) ? -opa : opa;
    b_mag = (sgn && opb[WIDTH-1]) ? -opb : opb;
    q_mag = '0;
    r_mag = '0;
    if (opb != '0) begin
      q_mag = a_mag / b_mag;
      r_mag = a_mag % b_mag;
    end
    quo = neg_q ? -q_mag : q_mag;
    rem = neg_r ? -r_mag : r_mag;
    if (opb == '0) begin
      quo = '1;
      rem = opa;
    end
  end

  // Next-state logic: accept in IDLE only, count down, commit on last count.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    opa_nxt   = opa;
    opb_nxt   = opb;
    sgn_nxt   = sgn;
    hi_nxt    = hi_reg;
    lo_nxt    = lo_reg;
    case (state)
      IDLE: begin
        if (bus.start) begin
          case (bus.op)
            3'd0, 3'd1: begin
              state_nxt = MUL;
              cnt_nxt   = CW'(MULT_CYCLES);
              opa_nxt   = bus.a;
              opb_nxt   = bus.b;
              sgn_nxt   = ~bus.op[0];
            end
            3'd2, 3'd3: begin
              state_nxt = DIV;
              cnt_nxt   = CW'(DIV_CYCLES);
              opa_nxt   = bus.a;
              opb_nxt   = bus.b;
              sgn_nxt   = ~bus.op[0];
            end
            3'd4:    hi_nxt = bus.a;
            3'd5:    lo_nxt = bus.a;
            default: ;
          endcase
        end
      end
      MUL: begin
        if (cnt == CW'(1)) begin
          state_nxt = IDLE;
          cnt_nxt   = '0;
          hi_nxt    = prod[2*WIDTH-1:WIDTH];
          lo_nxt    = prod[WIDTH-1:0];
        end else begin
          cnt_nxt = cnt - CW'(1);
        end
      end
      DIV: begin
        if (cnt == CW'(1)) begin
          state_nxt = IDLE;
          cnt_nxt   = '0;
          hi_nxt    = rem;
          lo_nxt    = quo;
        end else begin
          cnt_nxt = cnt - CW'(1);
        end
      end
      default: begin
        state_nxt = IDLE;
        cnt_nxt   = '0;
      end
    endcase
  end

  // State and HI/LO registers; reset wins over any pending start.
  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= IDLE;
      cnt    <= '0;
      opa    <= '0;
      opb    <= '0;
      sgn    <= 1'b0;
      hi_reg <= '0;
      lo_reg <= '0;
    end else begin
      state  <= state_nxt;
      cnt    <= cnt_nxt;
      opa    <= opa_nxt;
      opb    <= opb_nxt;
      sgn    <= sgn_nxt;
      hi_reg <= hi_nxt;
      lo_reg <= lo_nxt;
    end
  end

  // The accepting cycle also stalls so an MFHI/MFLO right behind waits.
  assign bus.busy  = (state != IDLE);
  assign bus.stall = !reset && ((state != IDLE) || (bus.start && !bus.op[2]));
  assign bus.hi    = hi_reg;
  assign bus.lo    = lo_reg;

endmodule
`default_nettype wire

// File: tb/tb_md_unit.sv
`default_nettype none
// ============================================================================
//  Module      : tb_md_unit
//  Description : Self-checking bench for md_unit: directed scenarios then
//                random traffic against an arithmetic reference model.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_md_unit;

  localparam int W  = 32;
  localparam int MC = 5;
  localparam int DC = 10;

  logic clk;
  logic reset;
  int   checks;
  int   errors;

  // Reference state: architectural HI/LO, cycles of busy still owed, and
  // the result that will be committed when that count reaches zero.
  logic [W-1:0] m_hi, m_lo, pend_hi, pend_lo;
  int           left;

  md_unit_if #(.WIDTH(W)) bus ();

  md_unit #(.WIDTH(W), .MULT_CYCLES(MC), .DIV_CYCLES(DC)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Result of an accepted op computed with plain integer arithmetic.
  task automatic model_result(input logic [2:0] o, input logic [W-1:0] av, input logic [W-1:0] bv,
                              output logic [W-1:0] rh, output logic [W-1:0] rl);
    int          sa, sb, q, r;
    longint      sp;
    logic [63:0] up;
    sa = av;
    sb = bv;
    case (o)
      3'd0: begin sp = longint'(sa) * longint'(sb); rh = sp[63:32]; rl = sp[31:0]; end
      3'd1: begin up = {32'b0, av} * {32'b0, bv}; rh = up[63:32]; rl = up[31:0]; end
      3'd2: begin
        if (bv == 0) begin rl = '1; rh = av; end
        else if (av == 32'h8000_0000 && bv == 32'hFFFF_FFFF) begin rl = av; rh = '0; end
        else begin q = sa / sb; r = sa % sb; rl = q; rh = r; end
      end
      default: begin
        if (bv == 0) begin rl = '1; rh = av; end
        else begin rl = av / bv; rh = av % bv; end
      end
    endcase
  endtask

  // One clock cycle: drive inputs, check stall, clock, advance model, check.
  task automatic cyc(input logic st, input logic [2:0] o, input logic [W-1:0] av,
                     input logic [W-1:0] bv, input logic rst);
    logic exp_stall;
    reset     = rst;
    bus.start = st;
    bus.op    = o;
    bus.a     = av;
    bus.b     = bv;
    #1;
    exp_stall = !rst && ((left > 0) || (st && o < 3'd4));
    check("stall", {63'b0, bus.stall}, {63'b0, exp_stall});
    @(posedge clk);
    if (rst) begin
      m_hi = '0; m_lo = '0; left = 0;
    end else if (left > 0) begin
      left--;
      if (left == 0) begin m_hi = pend_hi; m_lo = pend_lo; end
    end else if (st) begin
      if (o < 3'd4) begin
        model_result(o, av, bv, pend_hi, pend_lo);
        left = (o < 3'd2) ? MC : DC;
      end else if (o == 3'd4) m_hi = av;
      else if (o == 3'd5) m_lo = av;
    end
    #1;
    check("busy", {63'b0, bus.busy}, {63'b0, (left > 0)});
    check("hi", {32'b0, bus.hi}, {32'b0, m_hi});
    check("lo", {32'b0, bus.lo}, {32'b0, m_lo});
  endtask

  // Idle cycles with garbage operands to show they are not sampled.
  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(1'b0, 3'($urandom_range(0, 7)), $urandom, $urandom, 1'b0);
  endtask

  initial begin
    logic [W-1:0] ra, rb;
    logic [2:0]   ro;
    checks = 0; errors = 0;
    m_hi = '0; m_lo = '0; pend_hi = '0; pend_lo = '0; left = 0;
    reset = 1'b1; bus.start = 1'b0; bus.op = 3'd0; bus.a = '0; bus.b = '0;

    // Reset held with a start pending: stall must stay low, nothing accepted.
    cyc(1'b1, 3'd0, 32'h5, 32'h7, 1'b1);
    cyc(1'b1, 3'd2, 32'h5, 32'h7, 1'b1);
    check("reset_busy", {63'b0, bus.busy}, 64'd0);
    check("reset_hi", {32'b0, bus.hi}, 64'd0);

    // MULT -2 * 3
    cyc(1'b1, 3'd0, 32'hFFFF_FFFE, 32'd3, 1'b0);
    idle(MC);
    check("mult_hi", {32'b0, bus.hi}, 64'h0000_0000_FFFF_FFFF);
    check("mult_lo", {32'b0, bus.lo}, 64'h0000_0000_FFFF_FFFA);

    // MULTU 0xFFFFFFFF * 2
    cyc(1'b1, 3'd1, 32'hFFFF_FFFF, 32'd2, 1'b0);
    idle(MC);
    check("multu_hi", {32'b0, bus.hi}, 64'h1);
    check("multu_lo", {32'b0, bus.lo}, 64'hFFFF_FFFE);

    // DIV -7 / 2 with an MTHI attempted while busy
    cyc(1'b1, 3'd2, 32'hFFFF_FFF9, 32'd2, 1'b0);
    cyc(1'b1, 3'd4, 32'hDEAD_BEEF, 32'd0, 1'b0);
    idle(DC - 1);
    check("div_lo", {32'b0, bus.lo}, 64'hFFFF_FFFD);
    check("div_hi", {32'b0, bus.hi}, 64'hFFFF_FFFF);

    // DIVU 7 / 0
    cyc(1'b1, 3'd3, 32'd7, 32'd0, 1'b0);
    idle(DC);
    check("divu0_lo", {32'b0, bus.lo}, 64'hFFFF_FFFF);
    check("divu0_hi", {32'b0, bus.hi}, 64'h7);

    // MTLO, then signed overflow and signed divide by zero
    cyc(1'b1, 3'd5, 32'h1234_5678, 32'd0, 1'b0);
    check("mtlo_lo", {32'b0, bus.lo}, 64'h1234_5678);
    cyc(1'b1, 3'd2, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
    idle(DC);
    check("ovf_lo", {32'b0, bus.lo}, 64'h8000_0000);
    check("ovf_hi", {32'b0, bus.hi}, 64'h0);
    cyc(1'b1, 3'd2, 32'hFFFF_FF00, 32'd0, 1'b0);
    idle(DC);

    // Reset during cycle 4 of a DIV aborts it with no late update
    cyc(1'b1, 3'd2, 32'd100, 32'd7, 1'b0);
    idle(3);
    cyc(1'b0, 3'd0, 32'd0, 32'd0, 1'b1);
    check("abort_busy", {63'b0, bus.busy}, 64'd0);
    idle(DC + 2);
    check("abort_lo", {32'b0, bus.lo}, 64'd0);

    // Back-to-back: MULTU held at the input is accepted the cycle busy drops
    cyc(1'b1, 3'd0, 32'd9, 32'hFFFF_FFFD, 1'b0);
    for (int i = 0; i < 2 * MC + 1; i++) cyc(1'b1, 3'd1, 32'h8000_0001, 32'd3, 1'b0);
    idle(2);

    // Random traffic, including corner operands and occasional resets
    for (int i = 0; i < 400; i++) begin
      ro = 3'($urandom_range(0, 7));
      case ($urandom_range(0, 5))
        0:       ra = 32'h8000_0000;
        1:       ra = 32'($urandom_range(0, 20));
        default: ra = $urandom;
      endcase
      case ($urandom_range(0, 6))
        0:       rb = 32'd0;
        1:       rb = 32'hFFFF_FFFF;
        2:       rb = 32'($urandom_range(1, 9));
        default: rb = $urandom;
      endcase
      cyc(($urandom_range(0, 2) == 0), ro, ra, rb, ($urandom_range(0, 99) == 0));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/md_unit.md
MD_UNIT -- requirements
Module: md_unit

Interface
REQ-001 The block SHALL take parameter WIDTH, default 32, as the operand and HI/LO register width (WIDTH >= 2).
REQ-002 The block SHALL take parameter MULT_CYCLES, default 5, as the number of busy cycles for MULT/MULTU (>= 1).
REQ-003 The block SHALL take parameter DIV_CYCLES, default 10, as the number of busy cycles for DIV/DIVU (>= 1).
REQ-004 Port clk  input  1  is the single clock; all state SHALL update on its rising edge.
REQ-005 Port reset  input  1  SHALL be a synchronous, active-high reset.
REQ-006 Port start  input  1  SHALL mean that op/a/b are valid this cycle (instruction in EX).
REQ-007 Port op  input  3  SHALL encode 0=MULT, 1=MULTU, 2=DIV, 3=DIVU, 4=MTHI, 5=MTLO; codes 6 and 7 are no-op.
REQ-008 Port a  input  WIDTH  SHALL carry the forwarded RS operand.
REQ-009 Port b  input  WIDTH  SHALL carry the forwarded RT operand.
REQ-010 Port busy  output  1  SHALL be high while a multiply/divide is in progress.
REQ-011 Port stall  output  1  SHALL be the combinational stall request to the hazard unit.
REQ-012 Port hi  output  WIDTH  SHALL be the registered HI value.
REQ-013 Port lo  output  WIDTH  SHALL be the registered LO value.

Function
REQ-014 A start with op 0-3 while busy=0 SHALL be accepted, with a and b captured at that edge (cycle 0).
REQ-015 After acceptance, busy SHALL be 1 for exactly N cycles (N = MULT_CYCLES or DIV_CYCLES), i.e. cycles 1..N.
REQ-016 After acceptance, hi/lo SHALL change only at the edge ending cycle N, become visible in cycle N+1 together with busy=0, and hold their old values during cycles 1..N.
REQ-017 stall SHALL equal busy OR (start AND op in 0-3), so the accepting cycle also stalls MFHI/MFLO consumers.
REQ-018 MULT SHALL form the signed 2*WIDTH product with {hi,lo} = product.
REQ-019 MULTU SHALL form the unsigned 2*WIDTH product with {hi,lo} = product.
REQ-020 DIV SHALL produce lo = signed quotient truncated toward zero and hi = remainder carrying the dividend's sign.
REQ-021 DIVU SHALL produce lo = unsigned quotient and hi = remainder.
REQ-022 Division by zero (DIV or DIVU) SHALL give lo = all ones and hi = a, with the full DIV_CYCLES latency.
REQ-023 Signed overflow (a = most negative value, b = -1, DIV) SHALL give lo = a and hi = 0.
REQ-024 MTHI with start and busy=0 SHALL write hi = a at that edge, with no busy and no stall.
REQ-025 MTLO with start and busy=0 SHALL write lo = a at that edge, with no busy and no stall.
REQ-026 Any start (any op) while busy=1 SHALL be ignored, with no state change; upstream holds the instruction via stall.
REQ-027 The busy countdown SHALL be a counter sized for max(MULT_CYCLES, DIV_CYCLES).
REQ-028 Completion SHALL return to idle; a new start in the cycle busy falls to 0 SHALL be accepted.
REQ-029 The FSM SHALL have states IDLE, MUL, DIV and DONE, with DONE folded into the last count (no extra cycle).
REQ-030 Operand changes on a/b during busy SHALL NOT affect the result.

Reset
REQ-031 When reset=1 at an edge: hi=0, lo=0, busy=0, counter=0, state=IDLE.
REQ-032 Reset SHALL take priority over start.
REQ-033 Reset asserted mid-operation SHALL abort it, with no HI/LO update afterwards.
REQ-034 stall SHALL be 0 while reset is held, even if start is asserted.

Verification
REQ-035 MULT a=0xFFFFFFFE (-2), b=3 -> busy cycles 1-5; cycle 6: hi=0xFFFFFFFF, lo=0xFFFFFFFA, busy=0.
REQ-036 MULTU a=0xFFFFFFFF, b=2 -> after 5 busy cycles: hi=0x00000001, lo=0xFFFFFFFE.
REQ-037 DIV a=-7 (0xFFFFFFF9), b=2 -> 10 busy cycles; then lo=0xFFFFFFFD, hi=0xFFFFFFFF. DIVU a=7, b=0 -> lo=0xFFFFFFFF, hi=7.
REQ-038 MTLO a=0x12345678 -> lo=0x12345678 next cycle, busy and stall stay 0. MTHI issued during DIV busy -> hi unchanged.
REQ-039 Start DIV, assert reset in cycle 4 -> next cycle busy=0, hi=lo=0, and no update after.
REQ-040 Back-to-back: MULT completes, MULTU started the cycle busy drops -> accepted, busy continuous for 5 more cycles, stall continuous throughout.
